uart_tx_scheduler: RTL and testbench

- Shares one 8N1-style UART transmit line between NUM_REQ byte requesters using round-robin arbitration.
- Serialises each granted byte in time with the baud clock from the baud generator (its TX baud clock output, fed to bclk_in).
- Owns the generator's baud select and the generator's active-low reset.
- Applies baud-rate changes only between frames, then restarts the generator so the baud phase begins clean.

---
 rtl/uart_tx_scheduler.sv | 144 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART transmit line between NUM_REQ byte sources.
// Baud-rate changes are taken only between frames and restart the external baud generator.
module uart_tx_scheduler #(
   parameter int         NUM_REQ        = 4,
   parameter int         DATA_W         = 8,
   parameter int         GEN_RST_CYCLES = 2,
   parameter logic [1:0] BAUD_DEFAULT   = 2'b10,
   localparam int        GW             = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bclk_in,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [GW-1:0]             grant_id,
   input  logic                      cfg_valid,
   input  logic [1:0]                cfg_baud_sel,
   output logic                      cfg_ready,
   output logic [1:0]                baud_sel,
   output logic                      gen_rst_n,
   output logic                      tx,
   output logic                      tx_busy,
   output logic                      frame_done
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CFG   = 3'd1;
   localparam logic [2:0] START = 3'd2;
   localparam logic [2:0] DATA  = 3'd3;
   localparam logic [2:0] STOP  = 3'd4;

   localparam int CW = $clog2(DATA_W + 1);
   localparam int RW = $clog2(GEN_RST_CYCLES + 1);

   logic [2:0]        state;
   logic              bclk_d;
   logic              tick;
   logic [GW-1:0]     last_grant;
   logic [GW-1:0]     winner;
   logic [GW-1:0]     cand;
   logic              any_req;
   logic [DATA_W-1:0] shreg;
   logic [CW-1:0]     bit_cnt;
   logic [RW-1:0]     rst_cnt;

   assign tick      = bclk_in & ~bclk_d;
   assign cfg_ready = (state == IDLE);

   // Search upward from the slot after the previous winner, wrapping once.
   always_comb begin
      winner  = '0;
      cand    = '0;
      any_req = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = GW'((int'(last_grant) + k) % NUM_REQ);
         if (!any_req && req_valid[cand]) begin
            any_req = 1'b1;
            winner  = cand;
         end
      end
   end

   // A pending baud change outranks every byte request.
   always_comb begin
      req_ready = '0;
      if (state == IDLE && !cfg_valid && any_req)
         req_ready[winner] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bclk_d     <= 1'b0;
         tx         <= 1'b1;
         tx_busy    <= 1'b0;
         frame_done <= 1'b0;
         grant_id   <= '0;
         last_grant <= GW'(NUM_REQ - 1);
         baud_sel   <= BAUD_DEFAULT;
         gen_rst_n  <= 1'b0;
         shreg      <= '0;
         bit_cnt    <= '0;
         rst_cnt    <= '0;
      end else begin
         bclk_d     <= bclk_in;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               gen_rst_n <= 1'b1;
               if (cfg_valid) begin
                  baud_sel  <= cfg_baud_sel;
                  gen_rst_n <= 1'b0;
                  rst_cnt   <= RW'(GEN_RST_CYCLES);
                  state     <= CFG;
               end else if (any_req) begin
                  shreg      <= req_data[winner*DATA_W +: DATA_W];
                  grant_id   <= winner;
                  last_grant <= winner;
                  tx_busy    <= 1'b1;
                  state      <= START;
               end
            end
            CFG: begin
               if (rst_cnt == RW'(1)) begin
                  gen_rst_n <= 1'b1;
                  rst_cnt   <= '0;
                  state     <= IDLE;
               end else begin
                  rst_cnt <= rst_cnt - RW'(1);
               end
            end
            START: begin
               if (tick) begin
                  tx      <= 1'b0;
                  bit_cnt <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_cnt == CW'(DATA_W)) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= {1'b0, shreg[DATA_W-1:1]};
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  tx_busy    <= 1'b0;
                  frame_done <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: a round-robin plan model predicts frames,
// a line monitor decodes tx and pops the expectation at each frame_done.
module tb_uart_tx_scheduler;
   localparam int N  = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          bclk_in;
   logic [N-1:0]  req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]  req_ready;
   logic [1:0]    grant_id;
   logic          cfg_valid = 1'b0;
   logic [1:0]    cfg_baud_sel = 2'b00;
   logic          cfg_ready;
   logic [1:0]    baud_sel;
   logic          gen_rst_n;
   logic          tx;
   logic          tx_busy;
   logic          frame_done;

   uart_tx_scheduler #(.NUM_REQ(N), .DATA_W(DW), .GEN_RST_CYCLES(2), .BAUD_DEFAULT(2'b10)) dut (
      .clk(clk), .reset(reset), .bclk_in(bclk_in),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready), .grant_id(grant_id),
      .cfg_valid(cfg_valid), .cfg_baud_sel(cfg_baud_sel), .cfg_ready(cfg_ready),
      .baud_sel(baud_sel), .gen_rst_n(gen_rst_n),
      .tx(tx), .tx_busy(tx_busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int per_of(input logic [1:0] sel);
      case (sel)
         2'b00:   return 12;
         2'b01:   return 16;
         2'b10:   return 8;
         default: return 6;
      endcase
   endfunction

   // Baud generator model: period chosen by baud_sel, held idle while gen_rst_n is low.
   logic gen_bclk = 1'b0;
   logic manual = 1'b0;
   logic man_bclk = 1'b0;
   int   gcnt = 0;
   assign bclk_in = manual ? man_bclk : gen_bclk;
   initial forever begin
      @(posedge clk); #1;
      if (!gen_rst_n) begin
         gcnt = 0; gen_bclk = 1'b0;
      end else begin
         gcnt = (gcnt + 1) % per_of(baud_sel);
         gen_bclk = (gcnt >= per_of(baud_sel) / 2);
      end
   end

   typedef struct { int id; logic [7:0] data; } exp_t;
   exp_t       exp_q[$];
   int         ord_q[$];
   logic [7:0] bq[N][$];
   int         mptr = N - 1;
   logic [1:0] cur_sel = 2'b10;
   bit         mon_en = 1'b1;

   // Everything queued is presented at once and held, so grants follow pure rotation.
   task automatic plan();
      int cnt[N];
      int pos[N];
      int left;
      exp_t e;
      left = 0;
      for (int i = 0; i < N; i++) begin cnt[i] = bq[i].size(); pos[i] = 0; left += cnt[i]; end
      while (left > 0) begin
         for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (mptr + k) % N;
            if (cnt[idx] > 0) begin
               e.id = idx; e.data = bq[idx][pos[idx]];
               exp_q.push_back(e); ord_q.push_back(idx);
               pos[idx]++; cnt[idx]--; left--; mptr = idx;
               break;
            end
         end
      end
   endtask

   task automatic set_lines();
      for (int i = 0; i < N; i++) begin
         req_valid[i] = (bq[i].size() > 0);
         req_data[i*DW +: DW] = (bq[i].size() > 0) ? bq[i][0] : 8'h00;
      end
   endtask

   function automatic bit pending();
      for (int i = 0; i < N; i++) if (bq[i].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drive();
      int guard;
      int idx;
      int want;
      guard = 0;
      set_lines();
      while (pending() && guard < 4000) begin
         #1;
         if (req_ready != '0) begin
            idx = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
            want = (ord_q.size() > 0) ? ord_q.pop_front() : -1;
            chk("req_ready_onehot", $countones(req_ready), 1);
            chk("grant_order", idx, want);
            @(posedge clk); #1;
            void'(bq[idx].pop_front());
            set_lines();
         end else begin
            @(negedge clk); guard++;
         end
      end
      if (guard >= 4000) chk("drive_timeout", 1, 0);
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while ((exp_q.size() != 0 || tx_busy || !gen_rst_n) && g < 5000) begin @(negedge clk); g++; end
      if (g >= 5000) chk("idle_timeout", 1, 0);
      @(negedge clk);
   endtask

   task automatic do_cfg(input logic [1:0] sel);
      @(negedge clk);
      cfg_valid = 1'b1; cfg_baud_sel = sel;
      #1 chk("cfg_ready_idle", cfg_ready, 1);
      @(posedge clk); #1;
      cfg_valid = 1'b0; cur_sel = sel;
      @(negedge clk);
      chk("cfg_baud_sel", baud_sel, sel);
      wait_idle();
   endtask

   // Line monitor: decodes each frame at the expected bit period and scores it at frame_done.
   initial begin
      logic prev_tx;
      int   per;
      logic [9:0] bits;
      logic cur;
      bit   bad, abort_f, fd_ok;
      exp_t e;
      prev_tx = 1'b1;
      forever begin
         @(negedge clk);
         if (reset || !mon_en) begin prev_tx = 1'b1; continue; end
         if (prev_tx && !tx) begin
            per = per_of(cur_sel); bad = 0; abort_f = 0; fd_ok = 0; cur = 1'b0; bits = '0;
            for (int o = 0; o <= 10*per; o++) begin
               if (o > 0) @(negedge clk);
               if (reset) begin abort_f = 1; break; end
               if (o < 10*per) begin
                  if (o % per == 0) begin cur = tx; bits[o/per] = tx; end
                  else if (tx !== cur) bad = 1;
                  if (frame_done) bad = 1;
               end else begin
                  fd_ok = frame_done && !tx_busy && tx;
               end
            end
            if (!abort_f) begin
               chk("frame_shape", {bad, bits[0], bits[9]}, 3'b001);
               chk("frame_done_time", fd_ok, 1);
               if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk("tx_byte", bits[8:1], e.data);
                  chk("grant_id", grant_id, e.id);
               end
            end
         end
         prev_tx = tx;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int g, lowcnt, any;
      bit hold_bad;
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_baud_sel", baud_sel, 2'b10);
      chk("rst_gen_rst_n", gen_rst_n, 0);
      chk("rst_req_ready", req_ready, 0);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("gen_rst_n_release", gen_rst_n, 1);

      // single known frame
      bq[0].push_back(8'hA5); plan(); drive(); wait_idle();

      // all four requesters held for two frames each
      for (int i = 0; i < N; i++) repeat (2) bq[i].push_back(8'($urandom));
      plan(); drive(); wait_idle();

      // random batches at random baud rates
      for (int b = 0; b < 4; b++) begin
         do_cfg(2'($urandom));
         any = 0;
         for (int i = 0; i < N; i++) begin
            int c;
            c = $urandom_range(0, 2);
            repeat (c) bq[i].push_back(8'($urandom));
            any += c;
         end
         if (any == 0) bq[b % N].push_back(8'($urandom));
         plan(); drive(); wait_idle();
      end

      // cfg and request in the same idle cycle
      @(negedge clk);
      bq[1].push_back(8'($urandom)); plan(); set_lines();
      cfg_valid = 1'b1; cfg_baud_sel = 2'b01;
      #1;
      chk("coll_req_ready", req_ready, 0);
      chk("coll_cfg_ready", cfg_ready, 1);
      @(posedge clk); #1;
      cfg_valid = 1'b0; cur_sel = 2'b01;
      @(negedge clk);
      chk("coll_baud_sel", baud_sel, 2'b01);
      lowcnt = 0; g = 0; hold_bad = 0;
      while (!gen_rst_n && g < 20) begin
         if (req_ready != '0) hold_bad = 1;
         lowcnt++; @(negedge clk); g++;
      end
      chk("coll_gen_rst_low", lowcnt, 2);
      chk("coll_no_grant_in_cfg", hold_bad, 0);
      #1 chk("coll_grant1", req_ready, 4'b0010);
      drive(); wait_idle();

      // cfg raised mid-frame
      bq[3].push_back(8'($urandom)); plan(); drive();
      repeat (3 * per_of(cur_sel)) @(negedge clk);
      cfg_valid = 1'b1; cfg_baud_sel = 2'b00;
      hold_bad = 0; g = 0;
      while (!frame_done && g < 400) begin
         #1;
         if (cfg_ready || baud_sel !== cur_sel) hold_bad = 1;
         @(negedge clk); g++;
      end
      chk("cfg_hold_busy", hold_bad, 0);
      chk("cfg_ready_after_frame", cfg_ready, 1);
      chk("busy_after_frame", tx_busy, 0);
      @(posedge clk); #1;
      cfg_valid = 1'b0; cur_sel = 2'b00;
      @(negedge clk);
      chk("cfg_applied", baud_sel, 2'b00);
      chk("cfg_gen_rst", gen_rst_n, 0);
      wait_idle();

      // held-high baud clock advances exactly one bit
      mon_en = 1'b0; manual = 1'b1; man_bclk = 1'b0;
      bq[0].push_back(8'hB5); plan(); drive();
      @(negedge clk); man_bclk = 1'b1;
      repeat (20) @(negedge clk);
      chk("edge_start_bit", tx, 0);
      chk("edge_busy", tx_busy, 1);
      man_bclk = 1'b0; repeat (2) @(negedge clk);
      man_bclk = 1'b1; repeat (20) @(negedge clk);
      chk("edge_bit0", tx, 1);
      repeat (9) begin
         man_bclk = 1'b0; repeat (2) @(negedge clk);
         man_bclk = 1'b1; repeat (2) @(negedge clk);
      end
      chk("edge_frame_end", {tx_busy, tx}, 2'b01);
      exp_q.delete(); manual = 1'b0; mon_en = 1'b1;
      wait_idle();

      // reset during data bit 3
      bq[2].push_back(8'h96); plan(); drive();
      g = 0;
      while (tx && g < 300) begin @(negedge clk); g++; end
      if (g >= 300) chk("start_bit_timeout", 1, 0);
      repeat (4 * per_of(cur_sel) + per_of(cur_sel) / 2) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_busy", tx_busy, 0);
      chk("mid_rst_gen_rst_n", gen_rst_n, 0);
      exp_q.delete(); ord_q.delete(); mptr = N - 1; cur_sel = 2'b10;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_baud_sel", baud_sel, 2'b10);
      chk("post_rst_gen_rst_n", gen_rst_n, 1);
      for (int i = 0; i < N; i++) bq[i].push_back(8'($urandom));
      plan(); drive(); wait_idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
